// File: rtl/game_controller.sv
// Control FSM for a word-guessing game: word loading, guess compare with
// watchdog, reveal fill, and win/lose bookkeeping over an external datapath.
module game_controller #(
  parameter int MAX_LEN = 16,
  parameter int LIVES   = 6
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       go,
  input  logic       done_load,
  input  logic       loopend,
  input  logic       match,
  input  logic       filled,
  input  logic [4:0] remain,
  output logic       ld,
  output logic       wren,
  output logic       compare,
  output logic       rden,
  output logic       fill,
  output logic       writeorread,
  output logic [4:0] len,
  output logic [2:0] lives,
  output logic       win,
  output logic       lose,
  output logic       err
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_WAIT  = 4'd1,
    LOAD       = 4'd2,
    GUESS_WAIT = 4'd3,
    COMPARE    = 4'd4,
    EVAL       = 4'd5,
    FILL       = 4'd6,
    WIN        = 4'd7,
    LOSE       = 4'd8
  } state_t;

  localparam logic [4:0] MAX_LEN_V = 5'(MAX_LEN);
  localparam logic [2:0] LIVES_V   = 3'(LIVES);
  localparam logic [5:0] WD_LAST   = 6'(MAX_LEN + 1);

  state_t     state, state_n;
  logic       go_q;
  logic       go_rise;
  logic [4:0] len_n;
  logic [2:0] lives_n;
  logic       err_n;
  logic [5:0] wd, wd_n;
  logic       timeout, timeout_n;

  assign go_rise = go & ~go_q;

  // go_q resets high so a button held through reset is not seen as a press
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      state   <= IDLE;
      go_q    <= 1'b1;
      len     <= 5'd0;
      lives   <= LIVES_V;
      err     <= 1'b0;
      wd      <= 6'd0;
      timeout <= 1'b0;
    end else begin
      state   <= state_n;
      go_q    <= go;
      len     <= len_n;
      lives   <= lives_n;
      err     <= err_n;
      wd      <= wd_n;
      timeout <= timeout_n;
    end
  end

  always_comb begin
    state_n   = state;
    len_n     = len;
    lives_n   = lives;
    err_n     = err;
    wd_n      = wd;
    timeout_n = timeout;
    case (state)
      IDLE: begin
        if (go_rise) begin
          len_n   = 5'd0;
          lives_n = LIVES_V;
          err_n   = 1'b0;
          state_n = LOAD_WAIT;
        end
      end
      LOAD_WAIT: begin
        if (done_load && (len != 5'd0)) begin
          state_n = GUESS_WAIT;
        end else if (go_rise && (len < MAX_LEN_V)) begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (len < MAX_LEN_V) begin
          len_n = len + 5'd1;
        end
        if (len >= (MAX_LEN_V - 5'd1)) begin
          state_n = GUESS_WAIT;
        end else begin
          state_n = LOAD_WAIT;
        end
      end
      GUESS_WAIT: begin
        if (go_rise) begin
          wd_n      = 6'd0;
          timeout_n = 1'b0;
          state_n   = COMPARE;
        end
      end
      // A pass that never reports loopend is abandoned and scored as a miss
      COMPARE: begin
        if (loopend) begin
          state_n = EVAL;
        end else if (wd == WD_LAST) begin
          err_n     = 1'b1;
          timeout_n = 1'b1;
          state_n   = EVAL;
        end else begin
          wd_n = wd + 6'd1;
        end
      end
      EVAL: begin
        if (match && !timeout) begin
          state_n = FILL;
        end else begin
          if (lives != 3'd0) begin
            lives_n = lives - 3'd1;
          end
          if (lives <= 3'd1) begin
            state_n = LOSE;
          end else begin
            state_n = GUESS_WAIT;
          end
        end
      end
      FILL: begin
        if (filled) begin
          if (remain == 5'd0) begin
            state_n = WIN;
          end else begin
            state_n = GUESS_WAIT;
          end
        end
      end
      WIN, LOSE: begin
        if (go_rise) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Moore decode of the registered state
  always_comb begin
    ld          = 1'b0;
    wren        = 1'b0;
    compare     = 1'b0;
    rden        = 1'b0;
    fill        = 1'b0;
    writeorread = 1'b0;
    win         = 1'b0;
    lose        = 1'b0;
    case (state)
      LOAD_WAIT: writeorread = 1'b1;
      LOAD: begin
        writeorread = 1'b1;
        ld          = 1'b1;
        wren        = 1'b1;
      end
      COMPARE: begin
        compare = 1'b1;
        rden    = 1'b1;
      end
      FILL: begin
        fill = 1'b1;
        rden = 1'b1;
      end
      WIN:     win  = 1'b1;
      LOSE:    lose = 1'b1;
      default: writeorread = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller: three instances (default, LIVES=2,
// MAX_LEN=4) share stimulus; each task checks the instance it targets.
module tb_game_controller;

  logic       clk = 1'b0;
  logic       resetn, go, done_load, loopend, match, filled;
  logic [4:0] remain;

  logic       ld_a, wren_a, compare_a, rden_a, fill_a, wr_a, win_a, lose_a, err_a;
  logic [4:0] len_a;
  logic [2:0] lives_a;
  logic       ld_b, wren_b, compare_b, rden_b, fill_b, wr_b, win_b, lose_b, err_b;
  logic [4:0] len_b;
  logic [2:0] lives_b;
  logic       ld_c, wren_c, compare_c, rden_c, fill_c, wr_c, win_c, lose_c, err_c;
  logic [4:0] len_c;
  logic [2:0] lives_c;

  int errors = 0;
  int checks = 0;
  int ldc_a, dbl_a, wrc_a, cmpc_a, rdc_a, filc_a, ldc_c, cmpc_c;
  logic prev_ld_a;

  always #5 clk = ~clk;

  game_controller dut_a (
    .clk(clk), .resetn(resetn), .go(go), .done_load(done_load), .loopend(loopend),
    .match(match), .filled(filled), .remain(remain), .ld(ld_a), .wren(wren_a),
    .compare(compare_a), .rden(rden_a), .fill(fill_a), .writeorread(wr_a),
    .len(len_a), .lives(lives_a), .win(win_a), .lose(lose_a), .err(err_a));

  game_controller #(.MAX_LEN(16), .LIVES(2)) dut_b (
    .clk(clk), .resetn(resetn), .go(go), .done_load(done_load), .loopend(loopend),
    .match(match), .filled(filled), .remain(remain), .ld(ld_b), .wren(wren_b),
    .compare(compare_b), .rden(rden_b), .fill(fill_b), .writeorread(wr_b),
    .len(len_b), .lives(lives_b), .win(win_b), .lose(lose_b), .err(err_b));

  game_controller #(.MAX_LEN(4), .LIVES(6)) dut_c (
    .clk(clk), .resetn(resetn), .go(go), .done_load(done_load), .loopend(loopend),
    .match(match), .filled(filled), .remain(remain), .ld(ld_c), .wren(wren_c),
    .compare(compare_c), .rden(rden_c), .fill(fill_c), .writeorread(wr_c),
    .len(len_c), .lives(lives_c), .win(win_c), .lose(lose_c), .err(err_c));

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ld_a) ldc_a++;
    if (ld_a && prev_ld_a) dbl_a++;
    prev_ld_a = ld_a;
    if (wren_a) wrc_a++;
    if (compare_a) cmpc_a++;
    if (rden_a) rdc_a++;
    if (fill_a) filc_a++;
    if (ld_c) ldc_c++;
    if (compare_c) cmpc_c++;
  endtask

  task automatic clear_counts();
    ldc_a = 0; dbl_a = 0; wrc_a = 0; cmpc_a = 0; rdc_a = 0; filc_a = 0;
    ldc_c = 0; cmpc_c = 0; prev_ld_a = 1'b0;
  endtask

  task automatic press();
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc();
  endtask

  task automatic do_reset();
    go = 1'b0; done_load = 1'b0; loopend = 1'b0; match = 1'b0;
    filled = 1'b0; remain = 5'd0;
    resetn = 1'b1;
    cyc();
    cyc();
    resetn = 1'b0;
    cyc();
  endtask

  // IDLE -> LOAD_WAIT, n letters, done_load -> GUESS_WAIT
  task automatic setup_word(input int n);
    do_reset();
    press();
    for (int i = 0; i < n; i++) press();
    done_load = 1'b1;
    cyc();
    done_load = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b1; go = 1'b1; done_load = 1'b0; loopend = 1'b0;
    match = 1'b0; filled = 1'b0; remain = 5'd0;
    #2;
    checks++; if ({ld_a, wren_a, compare_a, rden_a, fill_a, wr_a, win_a, lose_a, err_a} !== 9'd0) begin errors++; $display("FAIL reset_outputs: got %b expected 0", {ld_a, wren_a, compare_a, rden_a, fill_a, wr_a, win_a, lose_a, err_a}); end
    checks++; if (len_a !== 5'd0) begin errors++; $display("FAIL reset_len: got %0d expected 0", len_a); end
    checks++; if (lives_a !== 3'd6) begin errors++; $display("FAIL reset_lives_a: got %0d expected 6", lives_a); end
    checks++; if (lives_b !== 3'd2) begin errors++; $display("FAIL reset_lives_b: got %0d expected 2", lives_b); end
    cyc();
    resetn = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL held_go_no_action: got %0b expected 0", wr_a); end
    go = 1'b0;
    cyc();
    go = 1'b1;
    cyc();
    checks++; if (wr_a !== 1'b1) begin errors++; $display("FAIL first_press_load_wait: got %0b expected 1", wr_a); end
    go = 1'b0;
    cyc();
    done_load = 1'b1;
    cyc();
    done_load = 1'b0;
    checks++; if (wr_a !== 1'b1) begin errors++; $display("FAIL done_load_len0_ignored: got %0b expected 1", wr_a); end
  endtask

  task automatic test_load();
    do_reset();
    press();
    clear_counts();
    for (int i = 0; i < 3; i++) press();
    checks++; if (ldc_a !== 3) begin errors++; $display("FAIL ld_pulses: got %0d expected 3", ldc_a); end
    checks++; if (wrc_a !== 3) begin errors++; $display("FAIL wren_pulses: got %0d expected 3", wrc_a); end
    checks++; if (dbl_a !== 0) begin errors++; $display("FAIL ld_single_cycle: got %0d expected 0", dbl_a); end
    checks++; if (wr_a !== 1'b1) begin errors++; $display("FAIL writeorread_loading: got %0b expected 1", wr_a); end
    done_load = 1'b1;
    cyc();
    done_load = 1'b0;
    checks++; if (len_a !== 5'd3) begin errors++; $display("FAIL load_len: got %0d expected 3", len_a); end
    checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL writeorread_guess: got %0b expected 0", wr_a); end
  endtask

  task automatic test_win();
    setup_word(3);
    clear_counts();
    match = 1'b1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    cyc(); cyc(); cyc();
    loopend = 1'b1;
    cyc();
    loopend = 1'b0;
    cyc();
    cyc();
    filled = 1'b1;
    cyc();
    filled = 1'b0;
    checks++; if (cmpc_a !== 4) begin errors++; $display("FAIL compare_cycles: got %0d expected 4", cmpc_a); end
    checks++; if (filc_a !== 2) begin errors++; $display("FAIL fill_cycles: got %0d expected 2", filc_a); end
    checks++; if (rdc_a !== 6) begin errors++; $display("FAIL rden_cycles: got %0d expected 6", rdc_a); end
    checks++; if (win_a !== 1'b1) begin errors++; $display("FAIL win: got %0b expected 1", win_a); end
    checks++; if (lives_a !== 3'd6) begin errors++; $display("FAIL win_lives: got %0d expected 6", lives_a); end
    match = 1'b0;
    press();
    checks++; if (win_a !== 1'b0) begin errors++; $display("FAIL win_to_idle: got %0b expected 0", win_a); end
  endtask

  task automatic test_lose();
    setup_word(1);
    match = 1'b0;
    for (int g = 0; g < 2; g++) begin
      go = 1'b1;
      cyc();
      go = 1'b0;
      loopend = 1'b1;
      cyc();
      loopend = 1'b0;
      if (g == 0) begin
        checks++; if (lives_b !== 3'd2) begin errors++; $display("FAIL lives_before_eval: got %0d expected 2", lives_b); end
      end
      cyc();
      if (g == 0) begin
        checks++; if (lives_b !== 3'd1) begin errors++; $display("FAIL lives_after_miss1: got %0d expected 1", lives_b); end
        checks++; if (lose_b !== 1'b0) begin errors++; $display("FAIL lose_early: got %0b expected 0", lose_b); end
      end
    end
    checks++; if (lives_b !== 3'd0) begin errors++; $display("FAIL lives_after_miss2: got %0d expected 0", lives_b); end
    checks++; if (lose_b !== 1'b1) begin errors++; $display("FAIL lose: got %0b expected 1", lose_b); end
    checks++; if (lives_a !== 3'd4) begin errors++; $display("FAIL lives_default_two_misses: got %0d expected 4", lives_a); end
  endtask

  task automatic test_timeout();
    setup_word(1);
    clear_counts();
    match = 1'b1;
    loopend = 1'b0;
    go = 1'b1;
    cyc();
    go = 1'b0;
    repeat (25) cyc();
    checks++; if (cmpc_a !== 18) begin errors++; $display("FAIL watchdog_cycles_a: got %0d expected 18", cmpc_a); end
    checks++; if (cmpc_c !== 6) begin errors++; $display("FAIL watchdog_cycles_c: got %0d expected 6", cmpc_c); end
    checks++; if (err_a !== 1'b1) begin errors++; $display("FAIL timeout_err: got %0b expected 1", err_a); end
    checks++; if (lives_a !== 3'd5) begin errors++; $display("FAIL timeout_lives: got %0d expected 5", lives_a); end
    checks++; if (compare_a !== 1'b0 || filc_a !== 0) begin errors++; $display("FAIL timeout_exit: compare=%0b fills=%0d expected 0/0", compare_a, filc_a); end
    match = 1'b0;
  endtask

  task automatic test_reset_mid_fill();
    setup_word(2);
    match = 1'b1;
    go = 1'b1;
    cyc();
    go = 1'b0;
    loopend = 1'b1;
    cyc();
    loopend = 1'b0;
    cyc();
    checks++; if (fill_a !== 1'b1) begin errors++; $display("FAIL in_fill: got %0b expected 1", fill_a); end
    go = 1'b1;
    resetn = 1'b1;
    #1;
    checks++; if (fill_a !== 1'b0 || rden_a !== 1'b0) begin errors++; $display("FAIL reset_kills_fill: fill=%0b rden=%0b expected 0/0", fill_a, rden_a); end
    checks++; if (len_a !== 5'd0) begin errors++; $display("FAIL reset_mid_fill_len: got %0d expected 0", len_a); end
    cyc();
    resetn = 1'b0;
    cyc(); cyc(); cyc();
    checks++; if (wr_a !== 1'b0) begin errors++; $display("FAIL go_held_over_reset: got %0b expected 0", wr_a); end
    go = 1'b0;
    match = 1'b0;
    cyc();
  endtask

  task automatic test_max_len();
    do_reset();
    press();
    clear_counts();
    for (int i = 0; i < 4; i++) press();
    checks++; if (len_c !== 5'd4) begin errors++; $display("FAIL maxlen_len: got %0d expected 4", len_c); end
    checks++; if (wr_c !== 1'b0) begin errors++; $display("FAIL maxlen_auto_guess_wait: got %0b expected 0", wr_c); end
    loopend = 1'b1;
    press();
    press();
    loopend = 1'b0;
    checks++; if (ldc_c !== 4) begin errors++; $display("FAIL maxlen_ld_pulses: got %0d expected 4", ldc_c); end
    checks++; if (len_c !== 5'd4) begin errors++; $display("FAIL maxlen_saturate: got %0d expected 4", len_c); end
    checks++; if (len_a !== 5'd6) begin errors++; $display("FAIL six_loads_default: got %0d expected 6", len_a); end
  endtask

  initial begin
    clear_counts();
    test_reset();
    test_load();
    test_win();
    test_lose();
    test_timeout();
    test_reset_mid_fill();
    test_max_len();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
